// File: rtl/serializador_pkg.sv
// Shared definitions for the serializer: counter sizing helper,
// default idle word and the shifter load-source encoding.
package serializador_pkg;

   localparam logic [9:0] SER_IDLE_WORD = 10'h17C;

   typedef enum logic [1:0] {
      LOAD_IDLE,
      LOAD_HOLD,
      LOAD_BYPASS
   } load_sel_t;

   // Ceil-log2 with a floor of 1 so a counter always has at least one bit.
   function automatic int ser_clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Parallel-load shifter; next_bit is the bit that goes on the line after
// the current one, in the transmit order selected by MSB_FIRST.
module ser_shift_reg #(
   parameter int                DATA_W     = 10,
   parameter bit                MSB_FIRST  = 1'b0,
   parameter logic [DATA_W-1:0] RESET_WORD = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] din,
   output logic              next_bit
);

   logic [DATA_W-1:0] sh;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh <= RESET_WORD;
      end else if (load) begin
         sh <= din;
      end else if (shift) begin
         sh <= MSB_FIRST ? {sh[DATA_W-2:0], 1'b0} : {1'b0, sh[DATA_W-1:1]};
      end
   end

   assign next_bit = MSB_FIRST ? sh[DATA_W-2] : sh[1];

endmodule

// File: rtl/serializador_param.sv
// Parallel-to-serial converter with a one-word holding buffer and idle fill.
// Define SER_PARITY_EN to append an even-parity bit to every frame.
module serializador_param
   import serializador_pkg::*;
#(
   parameter int          DATA_W    = 10,
   parameter bit          MSB_FIRST = 1'b0,
   parameter logic [63:0] IDLE_WORD = 64'(SER_IDLE_WORD)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ser_out,
   output logic              frame_start,
   output logic              data_frame
);

`ifdef SER_PARITY_EN
   localparam int FRAME_LEN = DATA_W + 1;
`else
   localparam int FRAME_LEN = DATA_W;
`endif
   localparam int                CNT_W = ser_clog2(FRAME_LEN);
   localparam logic [DATA_W-1:0] IDLE  = IDLE_WORD[DATA_W-1:0];

   logic [CNT_W-1:0]  cnt;
   logic              frame_end;
   logic [DATA_W-1:0] hold;
   logic              hold_full;
   load_sel_t         load_sel;
   logic [DATA_W-1:0] load_word;
   logic              first_bit;
   logic              next_bit;

   assign frame_end = (cnt == CNT_W'(FRAME_LEN - 1));
   assign in_ready  = rst_n && (!hold_full || frame_end);

   // A buffered word always wins over the bypass path so order is preserved.
   always_comb begin
      load_sel = LOAD_IDLE;
      if (hold_full) begin
         load_sel = LOAD_HOLD;
      end else if (in_valid) begin
         load_sel = LOAD_BYPASS;
      end
   end

   always_comb begin
      case (load_sel)
         LOAD_HOLD:   load_word = hold;
         LOAD_BYPASS: load_word = in_data;
         default:     load_word = IDLE;
      endcase
   end

   assign first_bit = MSB_FIRST ? load_word[DATA_W-1] : load_word[0];

   ser_shift_reg #(
      .DATA_W     (DATA_W),
      .MSB_FIRST  (MSB_FIRST),
      .RESET_WORD (IDLE)
   ) u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (frame_end),
      .shift    (!frame_end),
      .din      (load_word),
      .next_bit (next_bit)
   );

`ifdef SER_PARITY_EN
   // Parity is captured at load time because the shifter loses bits as it shifts.
   logic par;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par <= 1'b0;
      end else if (frame_end) begin
         par <= ^load_word;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= CNT_W'(FRAME_LEN - 1);
         ser_out     <= 1'b0;
         frame_start <= 1'b0;
         data_frame  <= 1'b0;
      end else if (frame_end) begin
         cnt         <= '0;
         ser_out     <= first_bit;
         frame_start <= 1'b1;
         data_frame  <= (load_sel != LOAD_IDLE);
      end else begin
         cnt         <= cnt + CNT_W'(1);
         frame_start <= 1'b0;
`ifdef SER_PARITY_EN
         ser_out     <= (cnt == CNT_W'(DATA_W - 1)) ? par : next_bit;
`else
         ser_out     <= next_bit;
`endif
      end
   end

   // On a frame boundary with the buffer draining, a new word refills it at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else if (frame_end) begin
         if (hold_full) begin
            hold_full <= in_valid;
            if (in_valid) hold <= in_data;
         end
      end else if (in_valid && !hold_full) begin
         hold      <= in_data;
         hold_full <= 1'b1;
      end
   end

endmodule

// File: tb/tb_serializador_param.sv
// Directed bench for serializador_param: idle fill, bypass, streaming,
// MSB-first ordering, optional parity and mid-frame reset.
module tb_serializador_param;

`ifdef SER_PARITY_EN
   localparam int FL = 11;
`else
   localparam int FL = 10;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       ser_out;
   logic       frame_start;
   logic       data_frame;

   logic [9:0] msb_data;
   logic       msb_valid;
   logic       msb_ready;
   logic       msb_ser;
   logic       msb_fs;
   logic       msb_df;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   serializador_param u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .ser_out     (ser_out),
      .frame_start (frame_start),
      .data_frame  (data_frame)
   );

   serializador_param #(.DATA_W(10), .MSB_FIRST(1'b1)) u_msb (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (msb_data),
      .in_valid    (msb_valid),
      .in_ready    (msb_ready),
      .ser_out     (msb_ser),
      .frame_start (msb_fs),
      .data_frame  (msb_df)
   );

   // bits: transmit order, leftmost literal bit goes out first
   typedef struct {
      logic       valid;
      logic [9:0] data;
      logic [9:0] bits;
      logic       df;
      logic       par;
   } vec_t;

   vec_t vecs[9];

   task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic valid, input logic [9:0] data);
      in_valid = valid;
      in_data  = data;
   endtask

   // Entered at the negedge of a frame's last bit; walks one whole frame.
   task automatic check_frame(input string tag, input logic [9:0] bits, input logic df, input logic par);
      for (int b = 0; b < FL; b++) begin
         @(negedge clk);
         if (b == 0) in_valid = 1'b0;
         if (b < 10) check_output($sformatf("%s bit%0d", tag, b), ser_out, bits[9-b]);
         else        check_output($sformatf("%s parity", tag), ser_out, par);
         check_output($sformatf("%s fs%0d", tag, b), frame_start, (b == 0));
         check_output($sformatf("%s df%0d", tag, b), data_frame, df);
         check_output($sformatf("%s rdy%0d", tag, b), in_ready, 1'b1);
      end
   endtask

   logic [9:0] stream_words[3];
   logic [9:0] stream_bits[3];
   logic       stream_par[3];

   initial begin
      int   widx;
      logic xfer;
      logic exp_rdy;
      int   f, b;

      vecs[0] = '{1'b0, 10'h000, 10'b0011111010, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 10'h000, 10'b0011111010, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 10'h000, 10'b0011111010, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 10'h3A5, 10'b1010010111, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 10'h000, 10'b0011111010, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 10'h007, 10'b1110000000, 1'b1, 1'b1};
      vecs[6] = '{1'b1, 10'h000, 10'b0000000000, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 10'h155, 10'b1010101010, 1'b1, 1'b1};
      vecs[8] = '{1'b1, 10'h2C1, 10'b1000001101, 1'b1, 1'b0};

      stream_words[0] = 10'h001; stream_bits[0] = 10'b1000000000; stream_par[0] = 1'b1;
      stream_words[1] = 10'h3FF; stream_bits[1] = 10'b1111111111; stream_par[1] = 1'b0;
      stream_words[2] = 10'h155; stream_bits[2] = 10'b1010101010; stream_par[2] = 1'b1;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      msb_valid = 1'b0;
      msb_data  = '0;

      repeat (3) @(negedge clk);
      check_output("rst ser_out", ser_out, 1'b0);
      check_output("rst frame_start", frame_start, 1'b0);
      check_output("rst data_frame", data_frame, 1'b0);
      check_output("rst in_ready", in_ready, 1'b0);
      check_output("rst msb ser_out", msb_ser, 1'b0);

      // MSB-first instance: 10'h200 offered on the very first frame_end edge
      msb_valid = 1'b1;
      msb_data  = 10'h200;
      rst_n     = 1'b1;
      for (int i = 0; i < FL; i++) begin
         @(negedge clk);
         if (i == 0) msb_valid = 1'b0;
         if (i < 10) check_output($sformatf("msb bit%0d", i), msb_ser, (i == 0));
         else        check_output("msb parity", msb_ser, 1'b1);
         check_output($sformatf("msb fs%0d", i), msb_fs, (i == 0));
         check_output($sformatf("msb df%0d", i), msb_df, 1'b1);
      end

      for (int v = 0; v < 9; v++) begin
         apply_stimulus(vecs[v].valid, vecs[v].data);
         check_frame($sformatf("vec%0d", v), vecs[v].bits, vecs[v].df, vecs[v].par);
      end

      // Streaming with valid/ready handshake; three frames back to back
      widx = 0;
      apply_stimulus(1'b1, stream_words[0]);
      for (int c = 0; c < 3 * FL; c++) begin
         xfer = in_valid && in_ready;
         @(negedge clk);
         if (xfer) widx++;
         if (widx < 3) apply_stimulus(1'b1, stream_words[widx]);
         else          in_valid = 1'b0;
         f = c / FL;
         b = c % FL;
         case (f)
            0:       exp_rdy = (b == 0) || (b == FL - 1);
            1:       exp_rdy = (b == FL - 1);
            default: exp_rdy = 1'b1;
         endcase
         if (b < 10) check_output($sformatf("stream f%0d bit%0d", f, b), ser_out, stream_bits[f][9-b]);
         else        check_output($sformatf("stream f%0d parity", f), ser_out, stream_par[f]);
         check_output($sformatf("stream f%0d df%0d", f, b), data_frame, 1'b1);
         check_output($sformatf("stream f%0d fs%0d", f, b), frame_start, (b == 0));
         check_output($sformatf("stream f%0d rdy%0d", f, b), in_ready, exp_rdy);
      end
      @(negedge clk);
      check_output("stream accepted", 16'(widx), 16'd3);
      check_output("post-stream fs", frame_start, 1'b1);
      check_output("post-stream df", data_frame, 1'b0);

      // Data frame in flight plus a held word, then reset at cnt=4
      repeat (FL - 1) @(negedge clk);
      apply_stimulus(1'b1, 10'h3A5);
      @(negedge clk);
      apply_stimulus(1'b1, 10'h155);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_output("midrst pre df", data_frame, 1'b1);
      check_output("midrst pre rdy", in_ready, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_output("midrst ser_out", ser_out, 1'b0);
      check_output("midrst frame_start", frame_start, 1'b0);
      check_output("midrst data_frame", data_frame, 1'b0);
      check_output("midrst in_ready", in_ready, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      check_frame("recover0", 10'b0011111010, 1'b0, 1'b0);
      check_frame("recover1", 10'b0011111010, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
